// File: rtl/frame_buffer_reader.sv
// Bus-master DMA: fetches a grayscale frame from SDRAM in line-bounded bursts and streams it out as bytes.
// Define FRAME_READER_LOOP_EN to restart at base after every frame instead of stopping after one.
module frame_buffer_reader #(
    parameter logic [7:0]  customInstructionId = 8'd0,
    parameter int unsigned fifoDepthLog2       = 5,
    parameter int unsigned maxBurstSize        = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ciStart,
    input  logic        ciCke,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic [31:0] ciResult,
    output logic        ciDone,
    output logic        requestBus,
    input  logic        busGrant,
    output logic        beginTransactionOut,
    output logic        readNotWriteOut,
    output logic [31:0] addressDataOut,
    output logic [3:0]  byteEnablesOut,
    output logic [7:0]  burstSizeOut,
    input  logic [31:0] addressDataIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    input  logic        busErrorIn,
    output logic [7:0]  pixelOut,
    output logic        pixelValidOut,
    input  logic        pixelReadyIn,
    output logic        lineStartOut,
    output logic        frameStartOut
);

    localparam int unsigned Depth    = 1 << fifoDepthLog2;
    localparam int unsigned CntW     = fifoDepthLog2 + 1;
    localparam logic [8:0]  MaxBurst = 9'(maxBurstSize);

    typedef enum logic [2:0] {IDLE, REQUEST, INIT, DATA, FINISH} state_t;

    state_t state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [8:0]  wpl_q, wpl_d;
    logic [10:0] lpf_q, lpf_d;
    logic        running_q, running_d, done_q, done_d, error_q, error_d, stop_q, stop_d;
    logic [31:0] wbase_q, wbase_d, line_addr_q, line_addr_d;
    logic [8:0]  wwpl_q, wwpl_d, word_cnt_q, word_cnt_d, burst_len_q, burst_len_d;
    logic [10:0] wlpf_q, wlpf_d, line_cnt_q, line_cnt_d;
    logic        begin_q, begin_d;
    logic [31:0] addr_out_q, addr_out_d;
    logic [7:0]  burst_out_q, burst_out_d;

    logic [31:0]              mem [Depth];
    logic [fifoDepthLog2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]          count_q, count_d;
    logic [31:0]              rd_word_q;
    logic                     rd_valid_q, rd_valid_d;

    logic [31:0] ser_word_q, ser_word_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        pix_valid_q, pix_valid_d, ls_q, ls_d, fs_q, fs_d;
    logic [8:0]  out_word_q, out_word_d;
    logic [10:0] out_line_q, out_line_d;

    logic        ci_sel, start_c, push, pop, load, accept, room_ok;
    logic [2:0]  op;
    logic [8:0]  remaining, len, nxt_word;
    logic [CntW-1:0] free_c;
    logic [28:0] unused_ci_a;

    assign op          = ciValueA[2:0];
    assign unused_ci_a = ciValueA[31:3];
    assign ci_sel      = ciStart & ciCke & (ciN == customInstructionId);
    assign ciDone      = ci_sel;
    assign ciResult    = !ci_sel      ? 32'd0 :
                         (op == 3'd0) ? base_q :
                         (op == 3'd5) ? {29'd0, error_q, done_q, running_q} : 32'd0;

    assign start_c = ci_sel & (op == 3'd4) & ciValueB[0] & ~running_q &
                     (wpl_q != 9'd0) & (lpf_q != 11'd0);

    // Bursts are clipped at the end of the line and granted only if the FIFO can take all of it
    assign remaining = wwpl_q - word_cnt_q;
    assign len       = (remaining > MaxBurst) ? MaxBurst : remaining;
    assign free_c    = CntW'(Depth) - count_q;
    assign room_ok   = 32'(free_c) >= 32'(len);
    assign nxt_word  = word_cnt_q + burst_len_q;

    assign accept = pix_valid_q & pixelReadyIn;
    assign load   = rd_valid_q & (~pix_valid_q | (accept & (byte_idx_q == 2'd3)));
    assign pop    = (count_q != '0) & (~rd_valid_q | load);
    assign push   = (state_q == DATA) & dataValidIn & (count_q != CntW'(Depth));

    assign requestBus          = (state_q == REQUEST);
    assign beginTransactionOut = begin_q;
    assign readNotWriteOut     = begin_q;
    assign byteEnablesOut      = {4{begin_q}};
    assign addressDataOut      = addr_out_q;
    assign burstSizeOut        = burst_out_q;

    assign pixelValidOut = pix_valid_q;
    assign pixelOut      = pix_valid_q ? 8'(ser_word_q >> {byte_idx_q, 3'b000}) : 8'd0;
    assign lineStartOut  = pix_valid_q & ls_q & (byte_idx_q == 2'd0);
    assign frameStartOut = pix_valid_q & fs_q & (byte_idx_q == 2'd0);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        wpl_d       = wpl_q;
        lpf_d       = lpf_q;
        running_d   = running_q;
        done_d      = done_q;
        error_d     = error_q;
        stop_d      = stop_q;
        wbase_d     = wbase_q;
        wwpl_d      = wwpl_q;
        wlpf_d      = wlpf_q;
        line_addr_d = line_addr_q;
        line_cnt_d  = line_cnt_q;
        word_cnt_d  = word_cnt_q;
        burst_len_d = burst_len_q;
        begin_d     = 1'b0;
        addr_out_d  = 32'd0;
        burst_out_d = 8'd0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CntW'(push) - CntW'(pop);
        rd_valid_d  = rd_valid_q;
        ser_word_d  = ser_word_q;
        byte_idx_d  = byte_idx_q;
        pix_valid_d = pix_valid_q;
        ls_d        = ls_q;
        fs_d        = fs_q;
        out_word_d  = out_word_q;
        out_line_d  = out_line_q;

        // Status-read clear comes first so that a same-cycle set below wins
        if (ci_sel) begin
            case (op)
                3'd1: base_d = {ciValueB[31:2], 2'b00};
                3'd2: wpl_d  = ciValueB[8:0];
                3'd3: lpf_d  = ciValueB[10:0];
                3'd4: if (!ciValueB[0] && running_q) stop_d = 1'b1;
                3'd5: begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (running_q && stop_q) begin
                    running_d = 1'b0;
                    stop_d    = 1'b0;
                end else if (running_q && (line_cnt_q < wlpf_q) && room_ok) begin
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                if (busGrant) begin
                    state_d     = INIT;
                    begin_d     = 1'b1;
                    addr_out_d  = line_addr_q + {21'd0, word_cnt_q, 2'b00};
                    burst_out_d = 8'(len - 9'd1);
                    burst_len_d = len;
                end
            end
            INIT: state_d = DATA;
            DATA: begin
                if (busErrorIn) begin
                    state_d   = IDLE;
                    error_d   = 1'b1;
                    running_d = 1'b0;
                    stop_d    = 1'b0;
                end else if (endTransactionIn) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (nxt_word == wwpl_q) begin
                    word_cnt_d  = 9'd0;
                    line_cnt_d  = line_cnt_q + 11'd1;
                    line_addr_d = line_addr_q + {21'd0, wwpl_q, 2'b00};
                    if (line_cnt_q + 11'd1 == wlpf_q) begin
                        done_d = 1'b1;
`ifdef FRAME_READER_LOOP_EN
                        line_cnt_d  = 11'd0;
                        line_addr_d = wbase_q;
`else
                        running_d = 1'b0;
                        stop_d    = 1'b0;
`endif
                    end
                end else begin
                    word_cnt_d = nxt_word;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        if (pop)       rd_valid_d = 1'b1;
        else if (load) rd_valid_d = 1'b0;

        // Line/frame markers follow the words as they leave, tracked independently of the fetch side
        if (load) begin
            ser_word_d  = rd_word_q;
            byte_idx_d  = 2'd0;
            pix_valid_d = 1'b1;
            ls_d        = (out_word_q == 9'd0);
            fs_d        = (out_word_q == 9'd0) && (out_line_q == 11'd0);
            if (out_word_q + 9'd1 == wwpl_q) begin
                out_word_d = 9'd0;
                out_line_d = (out_line_q + 11'd1 == wlpf_q) ? 11'd0 : out_line_q + 11'd1;
            end else begin
                out_word_d = out_word_q + 9'd1;
            end
        end else if (accept) begin
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) pix_valid_d = 1'b0;
        end

        if (start_c) begin
            wbase_d     = base_q;
            wwpl_d      = wpl_q;
            wlpf_d      = lpf_q;
            line_addr_d = base_q;
            line_cnt_d  = 11'd0;
            word_cnt_d  = 9'd0;
            running_d   = 1'b1;
            stop_d      = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            rd_valid_d  = 1'b0;
            pix_valid_d = 1'b0;
            byte_idx_d  = 2'd0;
            out_word_d  = 9'd0;
            out_line_d  = 11'd0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            base_q      <= 32'd0;
            wpl_q       <= 9'd0;
            lpf_q       <= 11'd0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            stop_q      <= 1'b0;
            wbase_q     <= 32'd0;
            wwpl_q      <= 9'd0;
            wlpf_q      <= 11'd0;
            line_addr_q <= 32'd0;
            line_cnt_q  <= 11'd0;
            word_cnt_q  <= 9'd0;
            burst_len_q <= 9'd0;
            begin_q     <= 1'b0;
            addr_out_q  <= 32'd0;
            burst_out_q <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            ser_word_q  <= 32'd0;
            byte_idx_q  <= 2'd0;
            pix_valid_q <= 1'b0;
            ls_q        <= 1'b0;
            fs_q        <= 1'b0;
            out_word_q  <= 9'd0;
            out_line_q  <= 11'd0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            wpl_q       <= wpl_d;
            lpf_q       <= lpf_d;
            running_q   <= running_d;
            done_q      <= done_d;
            error_q     <= error_d;
            stop_q      <= stop_d;
            wbase_q     <= wbase_d;
            wwpl_q      <= wwpl_d;
            wlpf_q      <= wlpf_d;
            line_addr_q <= line_addr_d;
            line_cnt_q  <= line_cnt_d;
            word_cnt_q  <= word_cnt_d;
            burst_len_q <= burst_len_d;
            begin_q     <= begin_d;
            addr_out_q  <= addr_out_d;
            burst_out_q <= burst_out_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            ser_word_q  <= ser_word_d;
            byte_idx_q  <= byte_idx_d;
            pix_valid_q <= pix_valid_d;
            ls_q        <= ls_d;
            fs_q        <= fs_d;
            out_word_q  <= out_word_d;
            out_line_q  <= out_line_d;
        end
    end

    // Word FIFO storage with registered read port
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= addressDataIn;
        if (pop)  rd_word_q <= mem[rd_ptr_q];
    end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Testbench for frame_buffer_reader: randomized bus slave and pixel sink, checked against a frame-level model.
module tb_frame_buffer_reader;

    localparam logic [7:0] ID = 8'd0;

    logic        clock = 1'b0;
    logic        reset;
    logic        ciStart = 0, ciCke = 0;
    logic [7:0]  ciN = 0;
    logic [31:0] ciValueA = 0, ciValueB = 0;
    logic [31:0] ciResult;
    logic        ciDone, requestBus, busGrant = 0;
    logic        beginTransactionOut, readNotWriteOut;
    logic [31:0] addressDataOut;
    logic [3:0]  byteEnablesOut;
    logic [7:0]  burstSizeOut;
    logic [31:0] addressDataIn = 0;
    logic        dataValidIn = 0, endTransactionIn = 0, busErrorIn = 0;
    logic [7:0]  pixelOut;
    logic        pixelValidOut, pixelReadyIn = 0, lineStartOut, frameStartOut;

    always #5 clock = ~clock;

    frame_buffer_reader dut (
        .clock(clock), .reset(reset),
        .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN), .ciValueA(ciValueA), .ciValueB(ciValueB),
        .ciResult(ciResult), .ciDone(ciDone),
        .requestBus(requestBus), .busGrant(busGrant),
        .beginTransactionOut(beginTransactionOut), .readNotWriteOut(readNotWriteOut),
        .addressDataOut(addressDataOut), .byteEnablesOut(byteEnablesOut), .burstSizeOut(burstSizeOut),
        .addressDataIn(addressDataIn), .dataValidIn(dataValidIn),
        .endTransactionIn(endTransactionIn), .busErrorIn(busErrorIn),
        .pixelOut(pixelOut), .pixelValidOut(pixelValidOut), .pixelReadyIn(pixelReadyIn),
        .lineStartOut(lineStartOut), .frameStartOut(frameStartOut)
    );

    int checks = 0, errors = 0;
    logic [31:0] seed;

    // environment state
    int s_state = 0, g_delay = 0, lat = 0, lat_cfg = 0, beat = 0, nbeats = 0;
    int req_count = 0, beats_total = 0, begin_bad = 0, err_beat = 0;
    bit err_en = 0, err_issued = 0, hold_ready = 0;
    logic [31:0] b_addr;
    logic [31:0] got_baddr[$];
    int          got_bsize[$];
    logic [9:0]  rx_pix[$];

    // reference model output
    logic [31:0] exp_baddr[$];
    int          exp_bsize[$];
    logic [9:0]  exp_pix[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bus slave: random grant delay, fixed latency, random beat gaps, optional error beat
    initial begin
        forever begin
            @(negedge clock);
            busGrant = 0; dataValidIn = 0; endTransactionIn = 0; busErrorIn = 0; addressDataIn = 0;
            if (!reset) s_state = 0;
            else begin
                case (s_state)
                    0: if (requestBus) begin
                        req_count++;
                        g_delay = $urandom_range(0, 2);
                        s_state = 1;
                    end
                    1: if (g_delay == 0) begin busGrant = 1; s_state = 2; end
                       else g_delay--;
                    2: if (beginTransactionOut) begin
                        if (!readNotWriteOut || byteEnablesOut != 4'hF) begin_bad++;
                        b_addr = addressDataOut;
                        nbeats = int'(burstSizeOut) + 1;
                        got_baddr.push_back(b_addr);
                        got_bsize.push_back(int'(burstSizeOut));
                        $display("burst addr=%h size=%0d", b_addr, burstSizeOut);
                        beat = 0; lat = lat_cfg; s_state = 3;
                    end
                    3: if (lat > 0) lat--; else s_state = 4;
                    4: if ($urandom_range(0, 3) != 0) begin
                        if (err_en && beat == err_beat) begin
                            busErrorIn = 1; err_issued = 1; s_state = 0;
                        end else begin
                            dataValidIn = 1;
                            addressDataIn = memf(b_addr + 32'(4 * beat));
                            beats_total++;
                            if (beat == nbeats - 1) begin endTransactionIn = 1; s_state = 0; end
                            beat++;
                        end
                    end
                    default: s_state = 0;
                endcase
            end
        end
    end

    // Pixel sink: random backpressure unless held; records {lineStart, frameStart, byte}
    initial begin
        forever begin
            @(negedge clock);
            pixelReadyIn = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (reset && pixelValidOut && pixelReadyIn)
                rx_pix.push_back({lineStartOut, frameStartOut, pixelOut});
        end
    end

    task automatic ci(input logic [2:0] op, input logic [31:0] b, output logic [31:0] res);
        @(negedge clock);
        ciStart = 1; ciCke = 1; ciN = ID; ciValueA = {29'd0, op}; ciValueB = b;
        #1;
        res = ciResult;
        chk("ci_done", ciDone, 1);
        @(negedge clock);
        ciStart = 0; ciCke = 0; ciValueA = 0; ciValueB = 0;
    endtask

    // Frame model: whole-frame byte stream and line-clipped burst list
    task automatic build_model(input logic [31:0] base, input int wpl, input int lpf);
        logic [31:0] d;
        int off, n;
        exp_baddr.delete(); exp_bsize.delete(); exp_pix.delete();
        for (int l = 0; l < lpf; l++) begin
            for (int w = 0; w < wpl; w++) begin
                d = memf(base + 32'((l * wpl + w) * 4));
                for (int b = 0; b < 4; b++)
                    exp_pix.push_back({(w == 0 && b == 0), (l == 0 && w == 0 && b == 0), d[8*b +: 8]});
            end
            off = 0;
            while (off < wpl) begin
                n = (wpl - off > 16) ? 16 : wpl - off;
                exp_baddr.push_back(base + 32'((l * wpl + off) * 4));
                exp_bsize.push_back(n - 1);
                off += n;
            end
        end
    endtask

    task automatic start_frame(input logic [31:0] base, input int wpl, input int lpf);
        logic [31:0] r;
        ci(3'd1, base, r);
        ci(3'd2, 32'(wpl), r);
        ci(3'd3, 32'(lpf), r);
        ci(3'd0, 0, r);
        chk("base_readback", r, base);
        ci(3'd5, 0, r);
        build_model(base, wpl, lpf);
        got_baddr.delete(); got_bsize.delete(); rx_pix.delete();
        begin_bad = 0;
        ci(3'd4, 1, r);
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int c = 0;
        while (rx_pix.size() < n && c < budget) begin @(negedge clock); c++; end
        chk(tag, rx_pix.size() >= n, 1);
    endtask

    task automatic cmp_bursts(input string tag, input int n);
        chk({tag, "_burst_count"}, got_baddr.size(), n);
        chk({tag, "_begin_signals"}, begin_bad, 0);
        for (int i = 0; i < n && i < got_baddr.size(); i++) begin
            chk($sformatf("%s_burst%0d_addr", tag, i), got_baddr[i], exp_baddr[i]);
            chk($sformatf("%s_burst%0d_size", tag, i), got_bsize[i], exp_bsize[i]);
        end
    endtask

    task automatic cmp_bytes(input string tag, input int n);
        for (int i = 0; i < n && i < rx_pix.size(); i++)
            chk($sformatf("%s_pix%0d", tag, i), {22'd0, rx_pix[i]}, {22'd0, exp_pix[i]});
    endtask

    initial begin
        logic [31:0] r, base;
        int r0, b0, c, vcount;
        #200000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
        r = 0;
    end

    initial begin
        logic [31:0] r, base;
        int r0, b0, c, vcount;
        seed = $urandom;
        reset = 1;
        #2 reset = 0;
        repeat (3) @(negedge clock);
        chk("reset_requestBus", requestBus, 0);
        chk("reset_begin", beginTransactionOut, 0);
        chk("reset_address", addressDataOut, 0);
        chk("reset_pixelValid", pixelValidOut, 0);
        reset = 1;
        ci(3'd5, 0, r); chk("reset_status", r, 0);
        ci(3'd0, 0, r); chk("reset_base", r, 0);

        // 1: two 4-word lines
        start_frame(32'h1000, 4, 2);
        wait_bytes("t1_bytes_timeout", 32, 3000);
        repeat (5) @(negedge clock);
        cmp_bursts("t1", 2);
        chk("t1_byte_count", rx_pix.size(), 32);
        cmp_bytes("t1", 32);
        ci(3'd5, 0, r); chk("t1_status", r, 32'b010);
        // unselected CI number returns zero
        @(negedge clock);
        ciStart = 1; ciCke = 1; ciN = 8'd7; ciValueA = 0;
        #1;
        chk("ci_unsel_done", ciDone, 0);
        chk("ci_unsel_result", ciResult, 0);
        @(negedge clock);
        ciStart = 0; ciCke = 0; ciN = ID;

        // 2: 40-word lines, slave latency 3
        lat_cfg = 3;
        base = $urandom; base = base & ~32'h3;
        start_frame(base, 40, 2);
        wait_bytes("t2_bytes_timeout", 320, 6000);
        repeat (5) @(negedge clock);
        cmp_bursts("t2", 6);
        cmp_bytes("t2", 320);
        ci(3'd5, 0, r); chk("t2_status", r, 32'b010);
        lat_cfg = 0;

        // 3: downstream stalled for 250 cycles
        hold_ready = 1;
        base = $urandom; base = base & ~32'h3;
        start_frame(base, 64, 1);
        repeat (100) @(negedge clock);
        r0 = req_count;
        repeat (150) @(negedge clock);
        chk("t3_no_request_while_full", req_count - r0, 0);
        chk("t3_fetched_some", got_baddr.size() >= 1, 1);
        chk("t3_no_output_while_held", rx_pix.size(), 0);
        hold_ready = 0;
        wait_bytes("t3_bytes_timeout", 256, 6000);
        repeat (5) @(negedge clock);
        cmp_bursts("t3", 4);
        cmp_bytes("t3", 256);
        ci(3'd5, 0, r); chk("t3_status", r, 32'b010);

        // 4: bus error on the third beat
        err_en = 1; err_beat = 2; err_issued = 0;
        base = $urandom; base = base & ~32'h3;
        start_frame(base, 16, 2);
        c = 0;
        while (!err_issued && c < 2000) begin @(negedge clock); c++; end
        chk("t4_error_issued", err_issued, 1);
        r0 = req_count;
        repeat (50) @(negedge clock);
        chk("t4_no_more_requests", req_count - r0, 0);
        chk("t4_requestBus_low", requestBus, 0);
        chk("t4_burst_count", got_baddr.size(), 1);
        ci(3'd5, 0, r); chk("t4_status_error", r, 32'b100);
        ci(3'd5, 0, r); chk("t4_status_cleared", r, 0);
        err_en = 0;

        // 5: stop during the first burst
        base = $urandom; base = base & ~32'h3;
        r0 = req_count;
        start_frame(base, 64, 4);
        c = 0;
        while (got_baddr.size() < 1 && c < 500) begin @(negedge clock); c++; end
        ci(3'd4, 0, r);
        wait_bytes("t5_bytes_timeout", 64, 3000);
        repeat (100) @(negedge clock);
        chk("t5_byte_count", rx_pix.size(), 64);
        chk("t5_burst_count", got_baddr.size(), 1);
        chk("t5_requests", req_count - r0, 1);
        cmp_bytes("t5", 64);
        ci(3'd5, 0, r); chk("t5_status", r, 0);

        // 6: reset during DATA
        base = $urandom; base = base & ~32'h3;
        b0 = beats_total;
        start_frame(base, 64, 2);
        c = 0;
        while (beats_total - b0 < 3 && c < 500) begin @(negedge clock); c++; end
        chk("t6_in_data", beats_total - b0 >= 3, 1);
        @(negedge clock);
        reset = 0;
        #1;
        chk("t6_requestBus", requestBus, 0);
        chk("t6_begin", beginTransactionOut, 0);
        chk("t6_rnw", readNotWriteOut, 0);
        chk("t6_address", addressDataOut, 0);
        chk("t6_byteEnables", byteEnablesOut, 0);
        chk("t6_burstSize", burstSizeOut, 0);
        chk("t6_pixel", pixelOut, 0);
        chk("t6_pixelValid", pixelValidOut, 0);
        chk("t6_lineStart", lineStartOut, 0);
        chk("t6_frameStart", frameStartOut, 0);
        chk("t6_ciResult", ciResult, 0);
        repeat (2) @(negedge clock);
        reset = 1;
        vcount = 0;
        repeat (20) begin
            @(negedge clock);
            if (pixelValidOut || requestBus) vcount++;
        end
        chk("t6_fifo_empty_idle", vcount, 0);
        ci(3'd5, 0, r); chk("t6_status", r, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
